// File: rtl/lowf_window_queue.sv
// lowf_window_queue: decimating circular sample queue for the low-frequency
// audio band. Every accepted sample is stored in a dual-port RAM; once WINDOW
// samples are held, each accepted sample triggers a burst of the most recent
// WINDOW samples (oldest first) towards the FIR MAC.
module lowf_window_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int WINDOW = 1020,
  parameter int DECIM  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] new_smpl,
  input  logic              wrt_smpl,
  output logic [DATA_W-1:0] smpl_out,
  output logic              smpl_vld,
  output logic              first_smpl,
  output logic              last_smpl,
  output logic              sequencing,
  output logic              full,
  output logic              overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(WINDOW);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       phase;
  logic [BW-1:0]       burst_idx;
  logic                pending;

  logic                accepted;
  logic                req;
  logic                start;
  logic                in_burst;
  logic                burst_last;

  // Decimation qualifier and burst request; clr drops a coincident strobe.
  always_comb begin
    accepted = wrt_smpl && !clr && (phase == PW'(DECIM - 1));
    req      = accepted && (cnt >= CW'(WINDOW - 1));
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    in_burst   = (state == BURST);
    burst_last = (state == BURST) && (burst_idx == BW'(WINDOW - 1));
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt = BURST;
          start     = 1'b1;
        end
      end
      BURST: begin
        if (burst_last) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      start     = 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Write side: decimation phase, write pointer and fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      phase  <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (wrt_smpl) begin
      if (accepted) begin
        phase  <= '0;
        wr_ptr <= wr_ptr + AW'(1);
        if (cnt != CW'(WINDOW)) cnt <= cnt + CW'(1);
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

  // Burst queueing: a single pending request, overrun when a second one arrives
  // while a burst is already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (clr) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending && !start) || req;
      if (req && sequencing && pending) overrun <= 1'b1;
    end
  end

  // Read side: read pointer and position within the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      burst_idx <= '0;
    end else if (clr) begin
      rd_ptr    <= '0;
      burst_idx <= '0;
    end else if (start) begin
      rd_ptr    <= wr_ptr - AW'(WINDOW);
      burst_idx <= '0;
    end else if (in_burst) begin
      rd_ptr    <= rd_ptr + AW'(1);
      burst_idx <= burst_idx + BW'(1);
    end
  end

  // Sample RAM write port; contents survive reset and clr.
  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= new_smpl;
  end

  // Sample RAM read port, one cycle latency.
  always_ff @(posedge clk) begin
    if (in_burst) rd_data <= mem[rd_ptr];
  end

  // Output qualifiers, aligned with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_vld   <= 1'b0;
      first_smpl <= 1'b0;
      last_smpl  <= 1'b0;
    end else if (clr) begin
      smpl_vld   <= 1'b0;
      first_smpl <= 1'b0;
      last_smpl  <= 1'b0;
    end else begin
      smpl_vld   <= in_burst;
      first_smpl <= in_burst && (burst_idx == '0);
      last_smpl  <= burst_last;
    end
  end

  // The read register has no reset so it can map onto RAM output flops;
  // gating with smpl_vld keeps smpl_out at 0 out of reset and between bursts.
  always_comb begin
    smpl_out   = smpl_vld ? rd_data : '0;
    sequencing = (state != IDLE);
    full       = (cnt == CW'(WINDOW));
  end

endmodule

// File: tb/tb_lowf_window_queue.sv
// Directed bench for lowf_window_queue: instance A uses DECIM=2, instance B
// uses DECIM=1 for the pending/overrun scenarios. Both use DEPTH=16, WINDOW=8.
module tb_lowf_window_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A
  logic        a_rst_n, a_clr, a_wrt;
  logic [15:0] a_data;
  logic [15:0] a_smpl_out;
  logic        a_vld, a_first, a_last, a_seq, a_full, a_ovr;

  // Instance B
  logic        b_rst_n, b_clr, b_wrt;
  logic [15:0] b_data;
  logic [15:0] b_smpl_out;
  logic        b_vld, b_first, b_last, b_seq, b_full, b_ovr;

  lowf_window_queue #(.DATA_W(16), .DEPTH(16), .WINDOW(8), .DECIM(2)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .clr(a_clr), .new_smpl(a_data), .wrt_smpl(a_wrt),
    .smpl_out(a_smpl_out), .smpl_vld(a_vld), .first_smpl(a_first), .last_smpl(a_last),
    .sequencing(a_seq), .full(a_full), .overrun(a_ovr)
  );

  lowf_window_queue #(.DATA_W(16), .DEPTH(16), .WINDOW(8), .DECIM(1)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .new_smpl(b_data), .wrt_smpl(b_wrt),
    .smpl_out(b_smpl_out), .smpl_vld(b_vld), .first_smpl(b_first), .last_smpl(b_last),
    .sequencing(b_seq), .full(b_full), .overrun(b_ovr)
  );

  // Bench-side model of instance A: accepted samples since last flush/reset.
  int hist[$];
  int ph = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after the accepting edge N; walks through the whole burst.
  task automatic a_burst_check;
    int base;
    base = hist.size() - 8;
    chk("lat_seq_n0", a_seq, 0);
    chk("lat_vld_n0", a_vld, 0);
    tick;
    chk("lat_seq_n1", a_seq, 1);
    chk("lat_vld_n1", a_vld, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("burst_vld", a_vld, 1);
      chk("burst_seq", a_seq, 1);
      chk("burst_data", a_smpl_out, hist[base + i]);
      chk("burst_first", a_first, (i == 0) ? 1 : 0);
      chk("burst_last", a_last, (i == 7) ? 1 : 0);
    end
    tick;
    chk("end_vld", a_vld, 0);
    chk("end_seq", a_seq, 0);
  endtask

  // One strobe on A followed by padding to gap cycles in total.
  task automatic a_strobe(input int d, input int gap);
    int used;
    bit acc;
    a_wrt  = 1'b1;
    a_data = 16'(d);
    tick;
    a_wrt  = 1'b0;
    used   = 1;
    acc    = (ph == 1);
    ph     = acc ? 0 : 1;
    if (acc) hist.push_back(d);
    chk("full", a_full, (hist.size() >= 8) ? 1 : 0);
    if (acc && hist.size() >= 8) begin
      a_burst_check();
      used = 11;
    end else begin
      chk("no_burst_seq", a_seq, 0);
    end
    for (int i = used; i < gap; i++) tick;
  endtask

  task automatic b_write(input int d);
    b_wrt  = 1'b1;
    b_data = 16'(d);
    tick;
    b_wrt  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst_n = 1'b0; a_clr = 1'b0; a_wrt = 1'b0; a_data = '0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_wrt = 1'b0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_smpl_out", a_smpl_out, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_first", a_first, 0);
    chk("rst_last", a_last, 0);
    chk("rst_seq", a_seq, 0);
    chk("rst_full", a_full, 0);
    chk("rst_ovr", a_ovr, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick;

    // Fill: 16 strobes, accepted samples 2,4,..,16, single burst at the end.
    for (int d = 1; d <= 16; d++) a_strobe(d, 4);

    // Sliding window with wrap: strobes 17..40, last burst 26,28,..,40.
    for (int d = 17; d <= 40; d++) a_strobe(d, 20);

    // clr mid-burst together with a strobe.
    a_strobe(41, 4);
    a_wrt = 1'b1; a_data = 16'd42;
    tick;
    a_wrt = 1'b0;
    hist.push_back(42);
    tick;
    tick;
    chk("clr_pre_vld", a_vld, 1);
    chk("clr_pre_data", a_smpl_out, hist[hist.size() - 8]);
    tick;
    a_clr = 1'b1; a_wrt = 1'b1; a_data = 16'd99;
    tick;
    a_clr = 1'b0; a_wrt = 1'b0;
    chk("clr_vld", a_vld, 0);
    chk("clr_seq", a_seq, 0);
    chk("clr_full", a_full, 0);
    chk("clr_ovr", a_ovr, 0);
    chk("clr_last", a_last, 0);
    tick;
    chk("clr_vld2", a_vld, 0);
    chk("clr_seq2", a_seq, 0);
    hist.delete();
    ph = 0;
    for (int d = 101; d <= 116; d++) a_strobe(d, 4);

    // Async reset mid-burst.
    a_strobe(117, 4);
    a_wrt = 1'b1; a_data = 16'd118;
    tick;
    a_wrt = 1'b0;
    hist.push_back(118);
    tick;
    tick;
    tick;
    chk("ar_pre_vld", a_vld, 1);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("ar_smpl_out", a_smpl_out, 0);
    chk("ar_vld", a_vld, 0);
    chk("ar_first", a_first, 0);
    chk("ar_last", a_last, 0);
    chk("ar_seq", a_seq, 0);
    chk("ar_full", a_full, 0);
    chk("ar_ovr", a_ovr, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    tick;
    chk("ar_post_vld", a_vld, 0);
    chk("ar_post_seq", a_seq, 0);
    hist.delete();
    ph = 0;
    for (int d = 119; d <= 134; d++) a_strobe(d, 4);

    // Instance B (DECIM=1): one write during a burst queues a second burst.
    for (int d = 1; d <= 7; d++) b_write(d);
    chk("b_full_7", b_full, 0);
    chk("b_seq_7", b_seq, 0);
    b_write(8);
    chk("b_full_8", b_full, 1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        b_wrt = 1'b1; b_data = 16'd9;
      end else begin
        b_wrt = 1'b0;
      end
      tick;
      chk("pend_seq", b_seq, ((k >= 1 && k <= 9) || (k >= 11 && k <= 19)) ? 1 : 0);
      chk("pend_vld", b_vld, ((k >= 2 && k <= 9) || (k >= 12 && k <= 19)) ? 1 : 0);
      chk("pend_first", b_first, (k == 2 || k == 12) ? 1 : 0);
      chk("pend_last", b_last, (k == 9 || k == 19) ? 1 : 0);
      chk("pend_ovr", b_ovr, 0);
      if (k >= 2 && k <= 9)   chk("pend_data1", b_smpl_out, k - 1);
      if (k >= 12 && k <= 19) chk("pend_data2", b_smpl_out, k - 10);
    end
    b_wrt = 1'b0;

    // Two writes inside one burst: overrun, sticky until clr.
    b_write(10);
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin
        b_wrt = 1'b1; b_data = 16'd11;
      end else if (k == 5) begin
        b_wrt = 1'b1; b_data = 16'd12;
      end else begin
        b_wrt = 1'b0;
      end
      tick;
      chk("ovr_flag", b_ovr, (k >= 5) ? 1 : 0);
      if (k == 10) chk("ovr_gap_seq", b_seq, 0);
      if (k == 11) chk("ovr_next_seq", b_seq, 1);
    end
    b_wrt = 1'b0;
    b_clr = 1'b1;
    tick;
    b_clr = 1'b0;
    chk("b_clr_ovr", b_ovr, 0);
    chk("b_clr_full", b_full, 0);
    chk("b_clr_seq", b_seq, 0);
    tick;
    chk("b_clr_seq2", b_seq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lowf_window_queue.md
# lowf_window_queue

Parametrised circular sample queue for the low-frequency band of the audio path. It decimates incoming samples by `DECIM` and stores them in an internal dual-port RAM. After each stored sample, once `WINDOW` samples are held, it streams the most recent `WINDOW` samples, oldest first, to the downstream FIR MAC as one burst. It replaces the fixed 1024x16, decimate-by-2 low-band queue with a fully synchronous, configurable version that adds overrun detection and a flush input.

## Interface
- `DATA_W`, default 16: sample width.
- `DEPTH`, default 1024: RAM entries. Must be a power of 2 and at least `WINDOW`+2.
- `WINDOW`, default 1020: samples per read burst (FIR tap count). Must be at least 2.
- `DECIM`, default 2: store one of every `DECIM` `wrt_smpl` strobes. Must be at least 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush.
- `new_smpl`  in  `DATA_W`  sample data, qualified by `wrt_smpl`.
- `wrt_smpl`  in  1  sample strobe. One-cycle pulse, sampled synchronously.
- `smpl_out`  out  `DATA_W`  burst sample data.
- `smpl_vld`  out  1  `smpl_out` valid this cycle.
- `first_smpl`  out  1  with `smpl_vld`: oldest sample of the burst.
- `last_smpl`  out  1  with `smpl_vld`: newest sample of the burst.
- `sequencing`  out  1  burst in progress.
- `full`  out  1  `WINDOW` samples held.
- `overrun`  out  1  sticky error flag.

## Operation
- Reset: all pointers, counters and flags are 0. `smpl_out`=0. Every output is 0.
- Decimation:
  - `phase` counts 0..`DECIM`-1 on each `wrt_smpl` and wraps to 0.
  - A strobe with `phase`==`DECIM`-1 is *accepted*. `DECIM`=1 accepts every strobe.
  - Non-accepted strobes only advance `phase`.
- Accepted write:
  - `new_smpl` is written to `wr_ptr`, then `wr_ptr` increments mod `DEPTH` (natural wrap).
  - `cnt` increments, saturating at `WINDOW`. `full` = (`cnt`==`WINDOW`).
- Burst trigger: an accepted write that leaves `full`=1 requests a burst.
- States: IDLE, BURST, DRAIN.
  - IDLE -> BURST on a request, or on `pending` set.
    - On entry, `base` = `wr_ptr` - `WINDOW` (mod `DEPTH`), `rd_ptr` = `base`, `pending` clears.
  - BURST: `rd_ptr` steps +1 per cycle for `WINDOW` cycles. After the `WINDOW`th address, go to DRAIN.
  - DRAIN: one cycle to output the last RAM read, then go to IDLE.
- `sequencing` = 1 in BURST and DRAIN.
- Accepted write while `sequencing`=1:
  - The sample is stored normally.
  - `pending` is set; the next burst starts from IDLE using the updated `wr_ptr`.
  - If `pending` is already 1, `overrun` sets (sticky). Only one burst stays queued.
  - Burst contents are guaranteed only while `overrun`=0.
- `clr`:
  - Zeroes `wr_ptr`, `rd_ptr`, `cnt`, `phase`, `pending`, `overrun`.
  - Aborts any burst: the state returns to IDLE next cycle with no further `smpl_vld`.
  - `clr` has priority over a simultaneous `wrt_smpl`; that sample is dropped and `phase` is not advanced.
- RAM contents are not cleared by reset or `clr`. Unwritten locations are never read, because `full` gates bursts.

## Timing
- Accepted write at edge N:
  - Request registered at edge N.
  - Edge N+1: IDLE->BURST; `sequencing`=1; first read address `base` issued.
  - RAM read latency is 1 cycle. `smpl_vld`=1 from edge N+2 through edge N+1+`WINDOW` (`WINDOW` consecutive cycles).
  - `first_smpl` is high on the first valid cycle; `last_smpl` on the final one.
  - `sequencing` is high for `WINDOW`+1 cycles and falls at edge N+2+`WINDOW`.
- Back-to-back bursts (`pending`): after DRAIN, IDLE lasts exactly 1 cycle, so `sequencing` is low for one cycle between bursts.
- `full` rises at the edge that stores the `WINDOW`th accepted sample.
- A write and a read to the same address in one cycle cannot occur while `overrun`=0, because `DEPTH` >= `WINDOW`+2.
- Async reset mid-burst: all outputs go to 0 immediately; a new burst needs `WINDOW` fresh accepted samples.

## Test plan
All scenarios use `DATA_W`=16, `DEPTH`=16, `WINDOW`=8, `DECIM`=2 unless stated.
- Fill: 16 strobes with data 1..16 at 4-cycle spacing.
  - `full` rises on the 16th strobe; its accepted samples are 2,4,..,16.
  - Exactly one burst: `smpl_out` = 2,4,6,..,16 on 8 consecutive `smpl_vld` cycles, with `first_smpl` on 2 and `last_smpl` on 16.
- Sliding window and wrap: continue to 40 strobes, one strobe every 20 cycles.
  - Each accepted sample yields a burst of the last 8 accepted samples.
  - The burst after strobe 40 is 26,28,..,40, with `wr_ptr` having wrapped past 15->0.
- Latency: accepted write at edge N gives `sequencing`=1 from edge N+1, first `smpl_vld` at N+2, last at N+9, and `sequencing`=0 at N+10.
- Pending and overrun (`DECIM`=1, window already full):
  - One write during a burst gives a second burst starting 1 idle cycle after DRAIN, with window shifted by 1; `overrun`=0.
  - A second write inside the same burst sets `overrun`=1, and it stays 1 until `clr`.
- `clr`: assert mid-burst, together with a `wrt_smpl`.
  - `smpl_vld`=0 from the next cycle; `full`=0; `overrun`=0; the sample is dropped.
  - 8 more accepted samples are needed before the next burst.
- Async reset: drop `rst_n` mid-burst; all outputs are 0 combinationally and stay 0 until the window refills.
